// File: rtl/vga_sync_if.sv
// VGA timing output bundle: pixel/line position, decoded sync/blank and strobes.
interface vga_sync_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       bright;
  logic       hsync;
  logic       vsync;
  logic       pix_en;
  logic       frame_start;

  modport master (
    output h_count, v_count, bright, hsync, vsync, pix_en, frame_start
  );

  modport slave (
    input h_count, v_count, bright, hsync, vsync, pix_en, frame_start
  );
endinterface

// File: rtl/vga_sync.sv
// 640x480 VGA timing generator: pixel clock divider, h/v raster counters,
// zero-skew registered sync/blank decode and a frame-start strobe.
module vga_sync #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  vga_sync_if.master vga
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] HS_FIRST = 10'd16;
  localparam logic [9:0] HS_LAST  = 10'd111;
  localparam logic [9:0] H_VIS    = 10'd160;
  localparam logic [9:0] V_LAST   = 10'd520;
  localparam logic [9:0] VS_FIRST = 10'd10;
  localparam logic [9:0] VS_LAST  = 10'd11;
  localparam logic [9:0] V_VIS    = 10'd41;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic          div_wrap;
  logic [9:0]    h_count;
  logic [9:0]    v_count;
  logic [9:0]    h_next;
  logic [9:0]    v_next;
  logic          h_wrap;
  logic          v_wrap;
  logic          bright;
  logic          hsync;
  logic          vsync;
  logic          pix_en;
  logic          frame_start;
  logic          bright_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          fs_next;

  // A divide-by-one divider wraps on every clock; larger dividers wrap at the
  // last count or on any out-of-range value.
  if (CLK_DIV == 1) begin : g_div1
    assign div_wrap = 1'b1;
  end else begin : g_divn
    assign div_wrap = (div_cnt >= DIV_LAST);
  end

  // Next-state counts and the decode of those counts, so the registered sync and
  // blank outputs change on the same edge as the counts they describe.
  always_comb begin
    div_next = div_wrap ? '0 : div_cnt + DW'(1);
    h_wrap   = (h_count >= H_LAST);
    v_wrap   = (v_count >= V_LAST);
    h_next   = h_count;
    v_next   = v_count;
    if (div_wrap) begin
      h_next = h_wrap ? '0 : h_count + 10'd1;
      if (h_wrap) begin
        v_next = v_wrap ? '0 : v_count + 10'd1;
      end
    end
    hsync_next  = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
    vsync_next  = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
    bright_next = (h_next >= H_VIS) && (h_next <= H_LAST) &&
                  (v_next >= V_VIS) && (v_next <= V_LAST);
    fs_next     = div_wrap && h_wrap && v_wrap;
  end

  // Timing state; en low freezes everything and silences the strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      h_count     <= '0;
      v_count     <= '0;
      bright      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      div_cnt     <= div_next;
      h_count     <= h_next;
      v_count     <= v_next;
      bright      <= bright_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      pix_en      <= div_wrap;
      frame_start <= fs_next;
    end else begin
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign vga.h_count     = h_count;
  assign vga.v_count     = v_count;
  assign vga.bright      = bright;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.pix_en      = pix_en;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: reset, first pixel, line/frame timing, pause, mid-frame
// reset, and divider settings 1, 2 and 4.
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst2;
  logic rst_aux;
  logic en2;
  logic en_aux = 1'b1;

  vga_sync_if bus2 ();
  vga_sync_if bus1 ();
  vga_sync_if bus4 ();

  vga_sync #(.CLK_DIV(2)) u_dut2 (.clk(clk), .reset_n(rst2),    .en(en2),    .vga(bus2));
  vga_sync #(.CLK_DIV(1)) u_dut1 (.clk(clk), .reset_n(rst_aux), .en(en_aux), .vga(bus1));
  vga_sync #(.CLK_DIV(4)) u_dut4 (.clk(clk), .reset_n(rst_aux), .en(en_aux), .vga(bus4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
    int br;
  } vec_t;

  vec_t tbl [14];
  vec_t sb [$];

  // ---------------- frame monitor for the CLK_DIV=2 instance ----------------
  bit mon_on = 1'b0;
  int fs_seen = 0;
  int clk2 = 0;
  int bcnt = 0;
  int vcnt = 0;
  bit dec_ok = 1'b1;
  int ph = 0;
  int pv = 0;
  int fr_bright [2];
  int fr_vs [2];
  int fr_dec [2];
  int fr_origin [2];
  int fs_clk [2];

  always @(negedge clk) begin
    if (mon_on && fs_seen < 2) begin
      int h;
      int v;
      bit exp_hs;
      bit exp_vs;
      bit exp_br;
      h = int'(bus2.h_count);
      v = int'(bus2.v_count);
      exp_hs = !(h >= 16 && h <= 111);
      exp_vs = !(v >= 10 && v <= 11);
      exp_br = (h >= 160 && h <= 799) && (v >= 41 && v <= 520);
      clk2++;
      if (bus2.pix_en && bus2.bright) bcnt++;
      if (bus2.pix_en && !bus2.vsync) vcnt++;
      if (bus2.hsync != exp_hs || bus2.vsync != exp_vs || bus2.bright != exp_br) dec_ok = 1'b0;
      if (bus2.frame_start) begin
        fr_origin[fs_seen] = (h == 0 && v == 0 && ph == 799 && pv == 520) ? 1 : 0;
        fr_bright[fs_seen] = bcnt;
        fr_vs[fs_seen]     = vcnt;
        fr_dec[fs_seen]    = dec_ok ? 1 : 0;
        fs_clk[fs_seen]    = clk2;
        bcnt   = 0;
        vcnt   = 0;
        dec_ok = 1'b1;
        fs_seen++;
      end
      if (bus2.pix_en) begin
        ph = h;
        pv = v;
      end
    end
  end

  // ---------------- divider-1 and divider-4 monitors ----------------
  bit aux_on = 1'b0;
  int c1 = 0, last1 = 0, fs1 = 0, npix1 = 0;
  int c4 = 0, last4 = 0, fs4 = 0, npix4 = 0;
  bit p1_ok = 1'b1, p4_ok = 1'b1, done1 = 1'b0, done4 = 1'b0;

  always @(negedge clk) begin
    if (aux_on && !done1) begin
      c1++;
      if (bus1.pix_en) begin
        if (c1 - last1 != 1) p1_ok = 1'b0;
        last1 = c1;
        npix1++;
      end
      if (bus1.frame_start) begin
        fs1   = c1;
        done1 = 1'b1;
      end
    end
    if (aux_on && !done4) begin
      c4++;
      if (bus4.pix_en) begin
        if (c4 - last4 != 4) p4_ok = 1'b0;
        last4 = c4;
        npix4++;
      end
      if (bus4.frame_start) begin
        fs4   = c4;
        done4 = 1'b1;
      end
    end
  end

  task automatic check_reset(string p);
    chk({p, "_h_count"},     int'(bus2.h_count),     0);
    chk({p, "_v_count"},     int'(bus2.v_count),     0);
    chk({p, "_bright"},      int'(bus2.bright),      0);
    chk({p, "_hsync"},       int'(bus2.hsync),       1);
    chk({p, "_vsync"},       int'(bus2.vsync),       1);
    chk({p, "_pix_en"},      int'(bus2.pix_en),      0);
    chk({p, "_frame_start"}, int'(bus2.frame_start), 0);
  endtask

  initial begin
    int fall_h, rise_h, lo_clks, lo_pix, br_seen, prev_hs, n, lim, hold_ok, vp;
    int hs0, vs0, br0, fs_any;
    vec_t e;

    // raster order within the first frame, after the first line
    tbl[0]  = '{h: 15,  v: 5,   hs: 1, vs: 1, br: 0};
    tbl[1]  = '{h: 16,  v: 5,   hs: 0, vs: 1, br: 0};
    tbl[2]  = '{h: 111, v: 5,   hs: 0, vs: 1, br: 0};
    tbl[3]  = '{h: 112, v: 5,   hs: 1, vs: 1, br: 0};
    tbl[4]  = '{h: 799, v: 9,   hs: 1, vs: 1, br: 0};
    tbl[5]  = '{h: 0,   v: 10,  hs: 1, vs: 0, br: 0};
    tbl[6]  = '{h: 20,  v: 11,  hs: 0, vs: 0, br: 0};
    tbl[7]  = '{h: 0,   v: 12,  hs: 1, vs: 1, br: 0};
    tbl[8]  = '{h: 160, v: 40,  hs: 1, vs: 1, br: 0};
    tbl[9]  = '{h: 159, v: 41,  hs: 1, vs: 1, br: 0};
    tbl[10] = '{h: 160, v: 41,  hs: 1, vs: 1, br: 1};
    tbl[11] = '{h: 799, v: 300, hs: 1, vs: 1, br: 1};
    tbl[12] = '{h: 50,  v: 520, hs: 0, vs: 1, br: 0};
    tbl[13] = '{h: 799, v: 520, hs: 1, vs: 1, br: 1};

    // reset asserted asynchronously, before any clock edge
    rst2 = 1'b1;
    rst_aux = 1'b1;
    en2 = 1'b1;
    #2;
    rst2 = 1'b0;
    rst_aux = 1'b0;
    #1;
    check_reset("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_h_count", int'(bus2.h_count), 0);
    chk("rst_hold_pix_en",  int'(bus2.pix_en),  0);

    // release on a falling edge, monitors start counting from the next edge
    rst2 = 1'b1;
    rst_aux = 1'b1;
    #1;
    mon_on = 1'b1;
    aux_on = 1'b1;

    // first pixel and one full line (v=0)
    fall_h = -1; rise_h = -1; lo_clks = 0; lo_pix = 0; br_seen = 0; prev_hs = 1;
    for (int i = 1; i <= 1600; i++) begin
      @(negedge clk);
      if (i <= 4) chk($sformatf("first_pix_en_%0d", i), int'(bus2.pix_en), (i % 2 == 0) ? 1 : 0);
      if (i == 2) chk("first_h_after_2", int'(bus2.h_count), 1);
      if (i == 4) chk("first_h_after_4", int'(bus2.h_count), 2);
      if (!bus2.hsync) begin
        lo_clks++;
        if (bus2.pix_en) lo_pix++;
        if (prev_hs == 1 && fall_h < 0) fall_h = int'(bus2.h_count);
      end else if (prev_hs == 0 && rise_h < 0) begin
        rise_h = int'(bus2.h_count);
      end
      if (bus2.bright) br_seen++;
      prev_hs = int'(bus2.hsync);
    end
    chk("line_hsync_fall_h", fall_h, 16);
    chk("line_hsync_rise_h", rise_h, 112);
    chk("line_hsync_low_clks", lo_clks, 192);
    chk("line_hsync_low_pix", lo_pix, 96);
    chk("line0_bright_clks", br_seen, 0);
    chk("line_end_h", int'(bus2.h_count), 0);
    chk("line_end_v", int'(bus2.v_count), 1);

    // decode table, checked through the scoreboard as the raster reaches each point
    lim = 850000;
    for (int i = 0; i < 14; i++) begin
      sb.push_back(tbl[i]);
      n = 0;
      while (!(int'(bus2.h_count) == tbl[i].h && int'(bus2.v_count) == tbl[i].v) && n < lim) begin
        @(negedge clk);
        n++;
      end
      e = sb.pop_front();
      if (n >= lim) begin
        chk($sformatf("vec%0d_reached", i), 0, 1);
        lim = 0;
      end else begin
        chk($sformatf("vec%0d_hsync", i),  int'(bus2.hsync),  e.hs);
        chk($sformatf("vec%0d_vsync", i),  int'(bus2.vsync),  e.vs);
        chk($sformatf("vec%0d_bright", i), int'(bus2.bright), e.br);
      end
    end

    // two complete frames
    n = 0;
    while (fs_seen < 2 && n < 1700000) begin
      @(negedge clk);
      n++;
    end
    chk("frames_seen", fs_seen, 2);
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("frame%0d_start_clk", f), fs_clk[f], 833600 * (f + 1));
      chk($sformatf("frame%0d_bright_pix", f), fr_bright[f], 307200);
      chk($sformatf("frame%0d_vsync_low_pix", f), fr_vs[f], 1600);
      chk($sformatf("frame%0d_decode", f), fr_dec[f], 1);
      chk($sformatf("frame%0d_start_at_wrap", f), fr_origin[f], 1);
    end

    // pause at h=300
    n = 0;
    while (!(bus2.pix_en && int'(bus2.h_count) == 300) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("pause_reached", (n < 4000) ? 1 : 0, 1);
    en2 = 1'b0;
    vp = int'(bus2.v_count);
    hs0 = int'(bus2.hsync);
    vs0 = int'(bus2.vsync);
    br0 = int'(bus2.bright);
    hold_ok = 1;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (int'(bus2.h_count) != 300 || int'(bus2.v_count) != vp || bus2.pix_en ||
          bus2.frame_start || int'(bus2.hsync) != hs0 || int'(bus2.vsync) != vs0 ||
          int'(bus2.bright) != br0) hold_ok = 0;
    end
    chk("pause_hold", hold_ok, 1);
    en2 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.pix_en && n < 10);
    chk("resume_clks_to_pix", n, 2);
    chk("resume_h_count", int'(bus2.h_count), 301);

    // reset pulse in the middle of a frame
    n = 0;
    while (!(int'(bus2.h_count) == 450 && int'(bus2.v_count) == 200) && n < 400000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reset_reached", (n < 400000) ? 1 : 0, 1);
    #2;
    rst2 = 1'b0;
    #1;
    check_reset("arst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b1;
    fs_any = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("restart_h_count", int'(bus2.h_count), 0);
        chk("restart_v_count", int'(bus2.v_count), 0);
        chk("restart_pix_en_1", int'(bus2.pix_en), 0);
      end
      if (i == 2) begin
        chk("restart_pix_en_2", int'(bus2.pix_en), 1);
        chk("restart_h_after_2", int'(bus2.h_count), 1);
      end
      if (bus2.frame_start) fs_any++;
    end
    chk("restart_no_frame_start", fs_any, 0);
    chk("restart_v_after_2000", int'(bus2.v_count), 1);

    // divider 1 and 4 instances
    n = 0;
    while (!(done1 && done4) && n < 2000000) begin
      @(negedge clk);
      n++;
    end
    chk("div1_period", int'(p1_ok), 1);
    chk("div1_frame_clks", fs1, 416800);
    chk("div1_pixels", npix1, 416800);
    chk("div4_period", int'(p4_ok), 1);
    chk("div4_frame_clks", fs4, 1667200);
    chk("div4_pixels", npix4, 416800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
